// File: rtl/display_mux_pkg.sv
// rtl/display_mux_pkg.sv - shared types and constants for the dual-digit display scanner
package display_mux_pkg;

  // Scan order is SHOW0 -> BLANK0 -> SHOW1 -> BLANK1 -> SHOW0
  typedef enum logic [1:0] {
    SHOW0  = 2'd0,
    BLANK0 = 2'd1,
    SHOW1  = 2'd2,
    BLANK1 = 2'd3
  } mux_state_t;

  // 1 ms lit time and 10 us dead time at 24 MHz
  localparam int DIV_CNT_DEFAULT   = 24000;
  localparam int BLANK_CNT_DEFAULT = 240;

  // Active-low anode enables; bit 0 is the right digit
  localparam logic [1:0] AN_OFF = 2'b11;
  localparam logic [1:0] AN_D0  = 2'b10;
  localparam logic [1:0] AN_D1  = 2'b01;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with synchronous active-low reset
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  // Shift the asynchronous input one stage per clock
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Both stages clear to zero in reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/display_mux.sv
// rtl/display_mux.sv - dual-digit scan with dead-time blanking; DISPLAY_MUX_SYNC_EN adds input synchronizers
module display_mux
  import display_mux_pkg::*;
#(
  parameter int DIV_CNT   = DIV_CNT_DEFAULT,
  parameter int BLANK_CNT = BLANK_CNT_DEFAULT
) (
  input  logic       int_osc,
  input  logic       reset_n,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic [3:0] nibble,
  output logic [1:0] an,
  output logic       digit
);

  localparam int CNT_MAX = (DIV_CNT > BLANK_CNT) ? DIV_CNT : BLANK_CNT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV_CNT - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CNT - 1);

  mux_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_last;
  logic [1:0]       an_q, an_d;
  logic [3:0]       nibble_q, nibble_d;
  logic             digit_q, digit_d;
  logic [3:0]       cap0, cap1;

`ifdef DISPLAY_MUX_SYNC_EN
  logic [7:0] s_sync;

  sync2 #(
    .WIDTH(8)
  ) u_sync2 (
    .clk    (int_osc),
    .resetn (reset_n),
    .d      ({s1, s0}),
    .q      (s_sync)
  );

  assign cap0 = s_sync[3:0];
  assign cap1 = s_sync[7:4];
`else
  assign cap0 = s0;
  assign cap1 = s1;
`endif

  // Next state: the shared counter times each state; outputs only move on transitions
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    an_d     = an_q;
    nibble_d = nibble_q;
    digit_d  = digit_q;
    cnt_last = ((state_q == SHOW0) || (state_q == SHOW1)) ? DIV_LAST : BLANK_LAST;

    if (cnt_q == cnt_last) begin
      cnt_d = '0;
      case (state_q)
        SHOW0: begin
          state_d = BLANK0;
          an_d    = AN_OFF;
        end
        BLANK0: begin
          // New value reaches the decoder only as the anode turns on after dead time
          state_d  = SHOW1;
          an_d     = AN_D1;
          nibble_d = cap1;
          digit_d  = 1'b1;
        end
        SHOW1: begin
          state_d = BLANK1;
          an_d    = AN_OFF;
        end
        BLANK1: begin
          state_d  = SHOW0;
          an_d     = AN_D0;
          nibble_d = cap0;
          digit_d  = 1'b0;
        end
        default: begin
          state_d = BLANK1;
          an_d    = AN_OFF;
        end
      endcase
    end
  end

  // State, counter and output registers; reset parks in BLANK1 so digit 0 lights first
  always_ff @(posedge int_osc) begin
    if (!reset_n) begin
      state_q  <= BLANK1;
      cnt_q    <= '0;
      an_q     <= AN_OFF;
      nibble_q <= 4'h0;
      digit_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      an_q     <= an_d;
      nibble_q <= nibble_d;
      digit_q  <= digit_d;
    end
  end

  assign nibble = nibble_q;
  assign an     = an_q;
  assign digit  = digit_q;

endmodule

// File: tb/tb_display_mux.sv
// tb/tb_display_mux.sv - randomized self-checking bench for display_mux against a scan-position model
module tb_display_mux;

  localparam int D = 4;
  localparam int B = 2;
  localparam int P = 2 * (D + B);
`ifdef DISPLAY_MUX_SYNC_EN
  localparam bit SYNC_ON = 1'b1;
`else
  localparam bit SYNC_ON = 1'b0;
`endif

  logic       int_osc = 1'b0;
  logic       reset_n;
  logic [3:0] s0, s1;
  logic [3:0] nibble;
  logic [1:0] an;
  logic       digit;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 int_osc = ~int_osc;

  display_mux #(
    .DIV_CNT   (D),
    .BLANK_CNT (B)
  ) dut (
    .int_osc (int_osc),
    .reset_n (reset_n),
    .s0      (s0),
    .s1      (s1),
    .nibble  (nibble),
    .an      (an),
    .digit   (digit)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: position within the scan period, counted in edges since the reset edge.
  // Period layout from the reset point: [0,B) dead, [B,B+D) digit 0, [B+D,2B+D) dead, [2B+D,P) digit 1.
  int         m_pos = 0;
  logic [1:0] m_an = 2'b11;
  logic [3:0] m_nib = 4'h0;
  logic       m_dig = 1'b1;
  bit         m_valid = 1'b0;
  bit         m_rst_edge = 1'b1;
  logic [7:0] hist1 = 8'h0, hist2 = 8'h0;
  logic [3:0] c0, c1;

  always @(posedge int_osc) begin
    m_valid = 1'b1;
    if (!reset_n) begin
      m_pos = 0; m_an = 2'b11; m_nib = 4'h0; m_dig = 1'b1;
      hist1 = 8'h0; hist2 = 8'h0; m_rst_edge = 1'b1;
    end else begin
      m_rst_edge = 1'b0;
      m_pos = (m_pos + 1) % P;
      c0 = SYNC_ON ? hist2[3:0] : s0;
      c1 = SYNC_ON ? hist2[7:4] : s1;
      if (m_pos == B) begin
        m_nib = c0; m_dig = 1'b0;
      end else if (m_pos == 2 * B + D) begin
        m_nib = c1; m_dig = 1'b1;
      end
      if (m_pos >= B && m_pos < B + D)  m_an = 2'b10;
      else if (m_pos >= 2 * B + D)      m_an = 2'b01;
      else                              m_an = 2'b11;
      hist2 = hist1;
      hist1 = {s1, s0};
    end
  end

  // Every-cycle compare against the model plus the two safety rules
  logic [1:0] prev_an = 2'b11;
  logic [3:0] prev_nib = 4'h0;

  always @(negedge int_osc) begin
    if (m_valid) begin
      check("an", {6'd0, an}, {6'd0, m_an});
      check("nibble", {4'd0, nibble}, {4'd0, m_nib});
      check("digit", {7'd0, digit}, {7'd0, m_dig});
      check("an_legal", {7'd0, an != 2'b00}, 8'd1);
      check("nibble_glitch",
            {7'd0, (nibble == prev_nib) || m_rst_edge || (prev_an == 2'b11 && an != 2'b11)}, 8'd1);
      prev_an  = an;
      prev_nib = nibble;
    end
  end

  logic [1:0] exp_an [12] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b01,
                              2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b10};
  logic [3:0] exp_nib [12];
  logic [3:0] first_nib;

  initial begin
    reset_n = 1'b0;
    s0 = 4'h3;
    s1 = 4'hA;
    first_nib = SYNC_ON ? 4'h0 : 4'h3;
    for (int i = 0; i < 12; i++)
      exp_nib[i] = (i < 5) ? first_nib : ((i < 11) ? 4'hA : 4'h3);

    // Reset and boot into digit 0 after the dead time
    repeat (3) @(negedge int_osc);
    check("rst_an", {6'd0, an}, 8'h03);
    check("rst_nibble", {4'd0, nibble}, 8'h00);
    check("rst_digit", {7'd0, digit}, 8'h01);
    reset_n = 1'b1;
    @(negedge int_osc);
    check("boot_blank_an", {6'd0, an}, 8'h03);
    @(negedge int_osc);
    check("boot_show0_an", {6'd0, an}, 8'h02);
    check("boot_show0_nib", {4'd0, nibble}, {4'd0, first_nib});
    check("boot_show0_digit", {7'd0, digit}, 8'h00);

    // One full steady period
    for (int i = 0; i < 12; i++) begin
      @(negedge int_osc);
      check("scan_an", {6'd0, an}, {6'd0, exp_an[i]});
      check("scan_nib", {4'd0, nibble}, {4'd0, exp_nib[i]});
    end

    // s0 changes during SHOW0: ignored until the next SHOW0 entry
    @(negedge int_osc);
    s0 = 4'h7;
    repeat (4) @(negedge int_osc);
    check("midshow_blank0_nib", {4'd0, nibble}, 8'h03);
    repeat (2) @(negedge int_osc);
    check("midshow_show1_nib", {4'd0, nibble}, 8'h0A);
    repeat (5) @(negedge int_osc);
    check("midshow_reentry_an", {6'd0, an}, 8'h02);
    check("midshow_reentry_nib", {4'd0, nibble}, 8'h07);

    // Reset arriving mid-SHOW1
    repeat (7) @(negedge int_osc);
    check("show1_an", {6'd0, an}, 8'h01);
    reset_n = 1'b0;
    @(negedge int_osc);
    check("midrst_an", {6'd0, an}, 8'h03);
    check("midrst_nibble", {4'd0, nibble}, 8'h00);
    check("midrst_digit", {7'd0, digit}, 8'h01);
    reset_n = 1'b1;
    @(negedge int_osc);
    check("midrst_blank_an", {6'd0, an}, 8'h03);
    @(negedge int_osc);
    check("midrst_show0_an", {6'd0, an}, 8'h02);
    check("midrst_show0_nib", {4'd0, nibble}, SYNC_ON ? 8'h00 : 8'h07);

    // Input change one cycle before SHOW0 entry
    s0 = 4'h5;
    repeat (10) @(negedge int_osc);
    s0 = 4'h9;
    repeat (2) @(negedge int_osc);
    check("latency_first", {4'd0, nibble}, SYNC_ON ? 8'h05 : 8'h09);
    repeat (12) @(negedge int_osc);
    check("latency_second", {4'd0, nibble}, 8'h09);

    // Random inputs with occasional resets
    repeat (2000) begin
      @(negedge int_osc);
      s0 = 4'($urandom_range(0, 15));
      s1 = 4'($urandom_range(0, 15));
      reset_n = ($urandom_range(0, 49) != 0);
    end
    @(negedge int_osc);
    reset_n = 1'b1;
    repeat (2) @(negedge int_osc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
